// File: rtl/mux_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_pkg : select codes and select type shared by the mux_4_1 block |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_I0 = 2'd0;
  localparam sel_t SEL_I1 = 2'd1;
  localparam sel_t SEL_I2 = 2'd2;
  localparam sel_t SEL_I3 = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mux_4_1_comb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_4_1_comb : pure combinational 4-to-1 select decode           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mux_4_1_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  sel_t             sel,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] w_y;

  always_comb begin
    w_y = i0;
    case (sel)
      SEL_I0:  w_y = i0;
      SEL_I1:  w_y = i1;
      SEL_I2:  w_y = i2;
      SEL_I3:  w_y = i3;
      default: w_y = i0;
    endcase
`ifndef SYNTHESIS
    // Make an unknown select visible in simulation rather than masking it as i0.
    if ($isunknown(sel)) w_y = 'x;
`endif
  end

  assign y = w_y;

endmodule
`default_nettype wire

// File: rtl/mux_4_1.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_4_1 : 4-to-1 mux with live output y and registered copy y_q  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mux_4_1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  sel_t             sel,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;

  mux_4_1_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .sel (sel),
    .i0  (i0),
    .i1  (i1),
    .i2  (i2),
    .i3  (i3),
    .y   (w_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_y_q <= '0;
    else        r_y_q <= w_y;
  end

  assign y   = w_y;
  assign y_q = r_y_q;

`ifndef SYNTHESIS
  logic [WIDTH-1:0] w_src [4];
  logic             r_past_valid = 1'b0;

  assign w_src = '{i0, i1, i2, i3};

  always_ff @(posedge clk) r_past_valid <= 1'b1;

  a_y_select: assert property (@(posedge clk)
    !$isunknown(sel) |-> (w_y == w_src[sel]));

  a_y_q_follow: assert property (@(posedge clk)
    (r_past_valid && $past(rst_n)) |-> (r_y_q == $past(w_y)));

  a_y_q_clear: assert property (@(posedge clk)
    (r_past_valid && !$past(rst_n)) |-> (r_y_q == '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_4_1.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mux_4_1 : directed self-checking bench, WIDTH=1 and WIDTH=8   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_mux_4_1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel1, sel8;
  logic [3:0] d1;
  logic [0:0] y1, yq1;
  logic [7:0] a0, a1, a2, a3, y8, yq8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_4_1 #(.WIDTH(1)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .sel (sel1),
    .i0 (d1[0]), .i1 (d1[1]), .i2 (d1[2]), .i3 (d1[3]),
    .y (y1), .y_q (yq1)
  );

  mux_4_1 #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst_n (rst_n), .sel (sel8),
    .i0 (a0), .i1 (a1), .i2 (a2), .i3 (a3),
    .y (y8), .y_q (yq8)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] pat;
    logic       exp1;
    logic       prev;
    pat   = 4'h5;
    rst_n = 1'b0;
    sel1  = 2'd0;
    d1    = 4'b0101;
    sel8  = 2'd2;
    a0 = 8'hA5; a1 = 8'h3C; a2 = 8'hFF; a3 = 8'h00;

    // Two edges in reset: y_q cleared, y stays live.
    @(negedge clk);
    @(negedge clk);
    chk1("rst_yq1", yq1[0], 1'b0);
    chk1("rst_y1", y1[0], 1'b1);
    chk8("rst_yq8", yq8, 8'h00);
    chk8("rst_y8", y8, 8'hFF);

    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("rel_yq1", yq1[0], 1'b1);
    chk8("rel_yq8", yq8, 8'hFF);
    prev = 1'b1;

    // Step sel 0..3 over pattern 0101.
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      sel1 = s[1:0];
      exp1 = pat[s];
      #1;
      chk1("step_y", y1[0], exp1);
      chk1("step_yq_hold", yq1[0], prev);
      @(posedge clk); #1;
      chk1("step_yq", yq1[0], exp1);
      prev = exp1;
    end

    // Random selects against the same pattern.
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      sel1 = 2'($urandom_range(0, 3));
      exp1 = pat[sel1];
      #1;
      chk1("rand_y", y1[0], exp1);
      @(posedge clk); #1;
      chk1("rand_yq", yq1[0], exp1);
    end

    // WIDTH=8: toggling non-selected sources must not disturb y.
    @(negedge clk);
    a0 = ~a0; #1;
    chk8("w8_tog_i0", y8, 8'hFF);
    a1 = ~a1; #1;
    chk8("w8_tog_i1", y8, 8'hFF);
    a3 = ~a3; #1;
    chk8("w8_tog_i3", y8, 8'hFF);
    sel8 = 2'd1; #1;
    chk8("w8_sel1", y8, 8'hC3);
    @(posedge clk); #1;
    chk8("w8_yq", yq8, 8'hC3);

    // Mid-stream single-edge reset pulse.
    @(negedge clk);
    sel1 = 2'd0;
    d1   = 4'b0101;
    @(posedge clk); #1;
    chk1("mid_pre_yq", yq1[0], 1'b1);
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk1("mid_sync_yq", yq1[0], 1'b1);
    @(posedge clk); #1;
    chk1("mid_rst_yq", yq1[0], 1'b0);
    chk1("mid_rst_y", y1[0], 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("mid_post_yq", yq1[0], 1'b1);
    prev = 1'b1;

    // Exhaustive WIDTH=1: all sel / data combinations.
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      sel1 = k[5:4];
      d1   = k[3:0];
      exp1 = d1[sel1];
      #1;
      chk1("exh_y", y1[0], exp1);
      chk1("exh_yq_hold", yq1[0], prev);
      @(posedge clk); #1;
      chk1("exh_yq", yq1[0], exp1);
      prev = exp1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
